// File: rtl/debounce_botoes_multicanal_if.sv
// Button bundle between the board pins and the consumers of debounced events.
// Signals:
//   entrada_raw   raw button pins, asynchronous to the system clock
//   estado        debounced level per channel, 1 = pressed
//   borda_press   one-cycle pulse when a channel becomes pressed
//   borda_release one-cycle pulse when a channel becomes released
//   repeticao     one-cycle auto-repeat pulse while a channel is held
//   qualquer      registered OR of press and repeat pulses over all channels
// Modports:
//   master  drives the pins and consumes the debounced events
//   slave   the debouncer itself
interface debounce_botoes_multicanal_if #(
    parameter int N_BOTOES = 4
);
    logic [N_BOTOES-1:0] entrada_raw;
    logic [N_BOTOES-1:0] estado;
    logic [N_BOTOES-1:0] borda_press;
    logic [N_BOTOES-1:0] borda_release;
    logic [N_BOTOES-1:0] repeticao;
    logic                qualquer;

    modport master (
        output entrada_raw,
        input  estado,
        input  borda_press,
        input  borda_release,
        input  repeticao,
        input  qualquer
    );

    modport slave (
        input  entrada_raw,
        output estado,
        output borda_press,
        output borda_release,
        output repeticao,
        output qualquer
    );
endinterface

// File: rtl/debounce_botoes_multicanal.sv
// Multi-channel push-button conditioner. Each channel is synchronised with two
// flip-flops, debounced with a disagreement counter, turned into press/release
// pulses and, optionally, auto-repeat pulses while the button stays held.
// Ports:
//   CLOCK  system clock, all state on the rising edge
//   RESET  asynchronous active-low reset
//   bus    slave side of debounce_botoes_multicanal_if (pins in, events out)
module debounce_botoes_multicanal #(
    parameter int N_BOTOES        = 4,
    parameter int ATIVO_BAIXO     = 1,
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int REPEAT_ATRASO   = 0,
    parameter int REPEAT_PERIODO  = 8
) (
    input  logic                           CLOCK,
    input  logic                           RESET,
    debounce_botoes_multicanal_if.slave    bus
);

    // Counter widths; a parameter of 1 still gets a 1-bit counter.
    localparam int CW   = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam int RMAX = (REPEAT_ATRASO > REPEAT_PERIODO) ? REPEAT_ATRASO : REPEAT_PERIODO;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] CNT_MAX     = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0] CNT_UM      = CW'(1);
    localparam logic [RW-1:0] ATRASO_MAX  = RW'((REPEAT_ATRASO > 0) ? (REPEAT_ATRASO - 1) : 0);
    localparam logic [RW-1:0] PERIODO_MAX = RW'((REPEAT_PERIODO > 0) ? (REPEAT_PERIODO - 1) : 0);
    localparam logic [RW-1:0] RCNT_UM     = RW'(1);
    localparam logic          REP_EN      = (REPEAT_ATRASO > 0);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ATRASO    = 2'd1,
        PERIODICO = 2'd2
    } rep_estado_t;

    logic [N_BOTOES-1:0] pol_s;
    logic [N_BOTOES-1:0] sync1_r;
    logic [N_BOTOES-1:0] sync2_r;
    logic [N_BOTOES-1:0] estado_v_s;
    logic [N_BOTOES-1:0] press_v_s;
    logic [N_BOTOES-1:0] release_v_s;
    logic [N_BOTOES-1:0] rep_v_s;
    logic                qualquer_r;

    // Normalise polarity so that 1 always means pressed from here on.
    always_comb begin
        if (ATIVO_BAIXO != 0) begin
            pol_s = ~bus.entrada_raw;
        end else begin
            pol_s = bus.entrada_raw;
        end
    end

    // Two-stage synchroniser; only sync2_r is used by the channel logic.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= pol_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar g = 0; g < N_BOTOES; g++) begin : g_canal
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          aceita_s;
        logic          press_acc_s;
        logic          rel_acc_s;
        logic          estado_r;
        logic          press_r;
        logic          release_r;
        logic          rep_r;
        rep_estado_t   rstate_r;
        rep_estado_t   rstate_nxt_s;
        logic [RW-1:0] rcnt_r;
        logic [RW-1:0] rcnt_nxt_s;
        logic          rep_pulse_s;

        // Disagreement counter: a new level is accepted only after it has been
        // seen on DEBOUNCE_CICLOS consecutive edges; any agreement restarts it.
        always_comb begin
            aceita_s  = 1'b0;
            cnt_nxt_s = cnt_r;
            if (sync2_r[g] == estado_r) begin
                cnt_nxt_s = '0;
            end else if (cnt_r == CNT_MAX) begin
                aceita_s  = 1'b1;
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + CNT_UM;
            end
        end

        assign press_acc_s = aceita_s & sync2_r[g];
        assign rel_acc_s   = aceita_s & ~sync2_r[g];

        // Debounced level, counter and the edge pulses, all updated on the accepting edge.
        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) begin
                cnt_r     <= '0;
                estado_r  <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                cnt_r     <= cnt_nxt_s;
                estado_r  <= aceita_s ? sync2_r[g] : estado_r;
                press_r   <= press_acc_s;
                release_r <= rel_acc_s;
            end
        end

        // Auto-repeat state and hold counter register.
        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) begin
                rstate_r <= OCIOSO;
                rcnt_r   <= '0;
                rep_r    <= 1'b0;
            end else begin
                rstate_r <= rstate_nxt_s;
                rcnt_r   <= rcnt_nxt_s;
                rep_r    <= rep_pulse_s;
            end
        end

        // Auto-repeat next state; an accepted release always wins.
        always_comb begin
            rstate_nxt_s = rstate_r;
            case (rstate_r)
                OCIOSO: begin
                    if (press_acc_s && REP_EN) begin
                        rstate_nxt_s = ATRASO;
                    end else begin
                        rstate_nxt_s = OCIOSO;
                    end
                end
                ATRASO: begin
                    if (rel_acc_s) begin
                        rstate_nxt_s = OCIOSO;
                    end else if (rcnt_r == ATRASO_MAX) begin
                        rstate_nxt_s = PERIODICO;
                    end else begin
                        rstate_nxt_s = ATRASO;
                    end
                end
                PERIODICO: begin
                    if (rel_acc_s) begin
                        rstate_nxt_s = OCIOSO;
                    end else begin
                        rstate_nxt_s = PERIODICO;
                    end
                end
                default: begin
                    rstate_nxt_s = OCIOSO;
                end
            endcase
        end

        // Auto-repeat outputs: hold counter update and the repeat pulse request.
        // The counter clears on every pulse so it never wraps.
        always_comb begin
            rep_pulse_s = 1'b0;
            rcnt_nxt_s  = '0;
            case (rstate_r)
                OCIOSO: begin
                    rcnt_nxt_s = '0;
                end
                ATRASO: begin
                    if (rel_acc_s) begin
                        rcnt_nxt_s = '0;
                    end else if (rcnt_r == ATRASO_MAX) begin
                        rep_pulse_s = 1'b1;
                        rcnt_nxt_s  = '0;
                    end else begin
                        rcnt_nxt_s = rcnt_r + RCNT_UM;
                    end
                end
                PERIODICO: begin
                    if (rel_acc_s) begin
                        rcnt_nxt_s = '0;
                    end else if (rcnt_r == PERIODO_MAX) begin
                        rep_pulse_s = 1'b1;
                        rcnt_nxt_s  = '0;
                    end else begin
                        rcnt_nxt_s = rcnt_r + RCNT_UM;
                    end
                end
                default: begin
                    rep_pulse_s = 1'b0;
                    rcnt_nxt_s  = '0;
                end
            endcase
        end

        assign estado_v_s[g]  = estado_r;
        assign press_v_s[g]   = press_r;
        assign release_v_s[g] = release_r;
        assign rep_v_s[g]     = rep_r;
    end

    // Summary pulse, one cycle behind the press/repeat pulses it covers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            qualquer_r <= 1'b0;
        end else begin
            qualquer_r <= |(press_v_s | rep_v_s);
        end
    end

    assign bus.estado        = estado_v_s;
    assign bus.borda_press   = press_v_s;
    assign bus.borda_release = release_v_s;
    assign bus.repeticao     = rep_v_s;
    assign bus.qualquer      = qualquer_r;

endmodule
